// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc layer-configuration path: config record,
// ctrl word map, STATUS bit positions and word packing helpers.
package qracc_pkg;

  typedef struct packed {
    logic [2:0]  n_input_bits_cfg;
    logic        binary_cfg;
    logic [2:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [31:0] input_fmap_size;
    logic [31:0] output_fmap_size;
    logic [31:0] input_fmap_dimx;
    logic [31:0] input_fmap_dimy;
    logic [31:0] output_fmap_dimx;
    logic [31:0] output_fmap_dimy;
    logic [9:0]  num_input_channels;
    logic [9:0]  num_output_channels;
  } qracc_config_t;

  typedef enum logic [3:0] {
    CFG_MODE          = 4'd0,
    CFG_IN_FMAP_SIZE  = 4'd1,
    CFG_OUT_FMAP_SIZE = 4'd2,
    CFG_IN_DIMX       = 4'd3,
    CFG_IN_DIMY       = 4'd4,
    CFG_OUT_DIMX      = 4'd5,
    CFG_OUT_DIMY      = 4'd6,
    CFG_CHAN          = 4'd7,
    CFG_COMMIT        = 4'd8,
    CFG_STATUS        = 4'd9,
    CFG_CLEAR         = 4'd10
  } qracc_cfg_word_e;

  localparam int CFG_STATUS_EMPTY_BIT = 0;
  localparam int CFG_STATUS_FULL_BIT  = 1;
  localparam int CFG_STATUS_ERR_BIT   = 2;
  localparam int CFG_STATUS_COUNT_LSB = 8;
  localparam int CFG_STATUS_COUNT_W   = 8;

  function automatic logic [31:0] pack_mode_word(qracc_config_t c);
    return {16'b0, c.filter_size_x, c.filter_size_y, 1'b0,
            c.adc_ref_range_shifts, c.binary_cfg, c.n_input_bits_cfg};
  endfunction

  function automatic logic [31:0] pack_chan_word(qracc_config_t c);
    return {6'b0, c.num_output_channels, 6'b0, c.num_input_channels};
  endfunction

endpackage

// File: rtl/qracc_cfg_ring.sv
// NUM_CTX-deep ring of config slots; head is read combinationally from the
// slot registers. Clear resets pointers only, slot contents are kept.
module qracc_cfg_ring
  import qracc_pkg::*;
#(
  parameter int NUM_CTX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      clear_i,
  input  qracc_config_t             data_i,
  output qracc_config_t             head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(NUM_CTX):0]  count_o
);

  localparam int PW = $clog2(NUM_CTX);

  qracc_config_t slots_q [NUM_CTX];
  qracc_config_t slots_d [NUM_CTX];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(NUM_CTX));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = slots_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        slots_d[wr_ptr_q] = data_i;
        wr_ptr_d          = wr_ptr_q + 1'b1;  // power-of-two depth wraps naturally
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) slots_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slots_q  <= slots_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/qracc_cfg_queue.sv
// Multi-context layer-config queue: ctrl-bus decode into a staging record,
// COMMIT pushes staging into the ring, layer_done_i pops the head.
module qracc_cfg_queue
  import qracc_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         ctrl_data_i,
  input  logic [ADDR_W-1:0]         ctrl_addr_i,
  input  logic                      ctrl_wen_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  output logic [DATA_W-1:0]         ctrl_read_data_o,
  output qracc_config_t             cfg_o,
  output logic                      cfg_valid_o,
  input  logic                      layer_done_i,
  output logic [$clog2(NUM_CTX):0]  cfg_count_o,
  output logic                      err_o
);

  logic [3:0]        word;
  logic              full, empty;
  logic              wr_acc, rd_acc, do_commit, do_clear, bad_write;
  qracc_config_t     staging_q, staging_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux;
  logic              err_q, err_d;
  logic              unused_addr;

  assign word        = ctrl_addr_i[5:2];
  assign unused_addr = ^{ctrl_addr_i[ADDR_W-1:6], ctrl_addr_i[1:0]};

  assign ctrl_ready_o = !(ctrl_wen_i && (word == CFG_COMMIT) && full);
  assign wr_acc       = ctrl_valid_i && ctrl_ready_o && ctrl_wen_i;
  assign rd_acc       = ctrl_valid_i && ctrl_ready_o && !ctrl_wen_i;
  assign do_commit    = wr_acc && (word == CFG_COMMIT);
  assign do_clear     = wr_acc && (word == CFG_CLEAR);
  assign bad_write    = wr_acc && ((word == CFG_STATUS) || (word > CFG_CLEAR));

  qracc_cfg_ring #(.NUM_CTX(NUM_CTX)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .push_i  (do_commit),
    .pop_i   (layer_done_i),
    .clear_i (do_clear),
    .data_i  (staging_q),
    .head_o  (cfg_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cfg_count_o)
  );

  assign cfg_valid_o      = !empty;
  assign err_o            = err_q;
  assign ctrl_read_data_o = rdata_q;

  always_comb begin
    staging_d = staging_q;
    if (wr_acc) begin
      case (word)
        CFG_MODE: begin
          staging_d.n_input_bits_cfg     = ctrl_data_i[2:0];
          staging_d.binary_cfg           = ctrl_data_i[3];
          staging_d.adc_ref_range_shifts = ctrl_data_i[6:4];
          staging_d.filter_size_y        = ctrl_data_i[11:8];
          staging_d.filter_size_x        = ctrl_data_i[15:12];
        end
        CFG_IN_FMAP_SIZE:  staging_d.input_fmap_size  = ctrl_data_i;
        CFG_OUT_FMAP_SIZE: staging_d.output_fmap_size = ctrl_data_i;
        CFG_IN_DIMX:       staging_d.input_fmap_dimx  = ctrl_data_i;
        CFG_IN_DIMY:       staging_d.input_fmap_dimy  = ctrl_data_i;
        CFG_OUT_DIMX:      staging_d.output_fmap_dimx = ctrl_data_i;
        CFG_OUT_DIMY:      staging_d.output_fmap_dimy = ctrl_data_i;
        CFG_CHAN: begin
          staging_d.num_input_channels  = ctrl_data_i[9:0];
          staging_d.num_output_channels = ctrl_data_i[25:16];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      CFG_MODE:          rd_mux = pack_mode_word(staging_q);
      CFG_IN_FMAP_SIZE:  rd_mux = staging_q.input_fmap_size;
      CFG_OUT_FMAP_SIZE: rd_mux = staging_q.output_fmap_size;
      CFG_IN_DIMX:       rd_mux = staging_q.input_fmap_dimx;
      CFG_IN_DIMY:       rd_mux = staging_q.input_fmap_dimy;
      CFG_OUT_DIMX:      rd_mux = staging_q.output_fmap_dimx;
      CFG_OUT_DIMY:      rd_mux = staging_q.output_fmap_dimy;
      CFG_CHAN:          rd_mux = pack_chan_word(staging_q);
      CFG_STATUS: begin
        rd_mux[CFG_STATUS_EMPTY_BIT] = empty;
        rd_mux[CFG_STATUS_FULL_BIT]  = full;
        rd_mux[CFG_STATUS_ERR_BIT]   = err_q;
        rd_mux[CFG_STATUS_COUNT_LSB +: CFG_STATUS_COUNT_W] = CFG_STATUS_COUNT_W'(cfg_count_o);
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = rd_acc ? rd_mux : rdata_q;
    err_d   = err_q;
    // CLEAR wins, so a pop on empty in the same cycle leaves err low
    if (do_clear)                                  err_d = 1'b0;
    else if ((layer_done_i && empty) || bad_write) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      staging_q <= staging_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/qracc_cfg_queue.md
Name: qracc_cfg_queue

Overview:
- Multi-context layer-configuration queue for QRAcc.
- Host writes per-layer fields over a 32-bit ctrl bus into a staging register, then commits it into a NUM_CTX-deep ring of qracc_config_t slots.
- The layer sequencer consumes the head slot (cfg_o) and pops it on layer_done_i, so layer N+1 config loads while layer N runs.
- Supersedes single-register config writes (I_WRITE_CONFIG).

Parameters:
- NUM_CTX, 4, ring depth; power of two, >=2
- ADDR_W, 32, ctrl address width; word index = ctrl_addr_i[5:2]
- DATA_W, 32, ctrl data width; fixed at 32

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ctrl_data_i  input  32  write data
- ctrl_addr_i  input  ADDR_W  byte address
- ctrl_wen_i  input  1  1=write, 0=read
- ctrl_valid_i  input  1  request valid
- ctrl_ready_o  output  1  request accepted when valid&ready
- ctrl_read_data_o  output  32  read return data
- cfg_o  output  $bits(qracc_config_t)  head-of-queue config
- cfg_valid_o  output  1  queue non-empty
- layer_done_i  input  1  pop head (one-cycle pulse)
- cfg_count_o  output  $clog2(NUM_CTX)+1  occupied slots
- err_o  output  1  sticky error flag

Behaviour:
- Interface: one clock domain, clocked on clk rising edge. Reset is asynchronous and active-high; the reset port is rst and the clock port is clk.
- Reset values:
  - staging, all slots, wr_ptr, rd_ptr and count = 0
  - cfg_o = 0, cfg_valid_o = 0, cfg_count_o = 0, err_o = 0
  - ctrl_read_data_o = 0, ctrl_ready_o = 1
- Word map (index = addr[5:2]; addr[1:0] and addr[ADDR_W-1:6] ignored):
  - 0: MODE. [2:0] n_input_bits_cfg, [3] binary_cfg, [6:4] adc_ref_range_shifts, [11:8] filter_size_y, [15:12] filter_size_x
  - 1: input_fmap_size
  - 2: output_fmap_size
  - 3: input_fmap_dimx
  - 4: input_fmap_dimy
  - 5: output_fmap_dimx
  - 6: output_fmap_dimy
  - 7: CHAN. [9:0] num_input_channels, [25:16] num_output_channels
  - 8: COMMIT. Write, any data.
  - 9: STATUS. Read-only: [0] empty, [1] full, [2] err, [15:8] count.
  - 10: CLEAR. Write, any data.
  - 11-15: reserved.
- Handshake:
  - ctrl_ready_o = !(ctrl_wen_i && word==COMMIT && full). Combinational, independent of layer_done_i.
  - All other requests are accepted in the same cycle they are presented.
- Writes to words 0-7 update the staging field on the accept edge. Unused bits are dropped.
- Reads:
  - ctrl_read_data_o is registered on the accept edge and holds until the next accepted read.
  - Words 0-7 return staging contents, zero-extended.
  - Word 9 returns STATUS.
  - Words 8, 10 and 11-15 return 0.
- COMMIT when accepted:
  - slot[wr_ptr] <= staging; wr_ptr wraps modulo NUM_CTX; count++.
  - Staging is retained, so only changed fields need rewriting.
- Pop (layer_done_i=1, !empty): rd_ptr wraps modulo NUM_CTX; count--. Pop on empty is ignored and sets err.
- COMMIT and pop in the same cycle (non-full, non-empty): both occur and count is unchanged.
  - COMMIT on full stalls even if a pop occurs that cycle; it is accepted on the next cycle.
  - Commit+pop on empty: the commit proceeds and the pop is ignored with err set.
- cfg_o = slot[rd_ptr], read combinationally from registered slot storage. Slot contents are not cleared on pop.
- CLEAR:
  - Sets wr_ptr = rd_ptr = count = 0 and err = 0.
  - Staging and slots are retained.
  - CLEAR wins over a simultaneous pop.
- Write to a reserved word (11-15) or to STATUS: accepted, no effect, sets err.
- err is cleared only by CLEAR or rst.
- Reset mid-transaction: an in-flight request is dropped; the master must reissue it.

Decomposition:
- Add to qracc_pkg:
  - qracc_cfg_word_e enum, words 0-10
  - localparam CFG_STATUS_EMPTY_BIT etc.
  - function pack_mode_word(qracc_config_t) for bench and firmware model
- Sub-module qracc_cfg_ring: generic NUM_CTX-deep register ring of qracc_config_t with push/pop/clear, full/empty/count.
- The top level holds the address decode, staging register and read mux.

Test Plan:
1. Write MODE=0x0000_3224, words 1-7, then COMMIT. Next cycle: cfg_valid_o=1, cfg_o.n_input_bits_cfg=4, filter_size_x=3, filter_size_y=2, adc_ref_range_shifts=2; cfg_count_o=1.
2. Commit 4 configs with input_fmap_dimx=1..4. A 5th COMMIT must see ctrl_ready_o=0. Pulse layer_done_i once: the stalled COMMIT is accepted the following cycle. cfg_o.input_fmap_dimx sequence on successive pops is 2,3,4,(4 from 5th commit).
3. At count=2, COMMIT and layer_done_i in the same cycle -> count stays 2 and head advances by one.
4. layer_done_i on empty -> err_o=1, count=0. STATUS read returns 0x0000_0005. CLEAR -> err_o=0 and STATUS returns 0x0000_0001.
5. Write to word 12 -> accepted, err_o=1, staging unchanged. Read word 12 -> 0.
6. Assert rst with count=3 for one cycle mid-COMMIT, asynchronous to clk -> all outputs return to their reset values immediately; cfg_valid_o=0 and cfg_count_o=0.
